// File: rtl/cross_entropy_lut_arbiter_if.sv
// Request/response bundle between the requesters, the shared gradient table and the arbiter.
// The slave modport is the arbiter's view and the master modport is the requesters/table side.
interface cross_entropy_lut_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int IN_W  = 12,
    parameter int OUT_W = 13,
    parameter int ID_W  = $clog2(N_REQ)
);
    logic [N_REQ-1:0]      req_valid;
    logic [N_REQ-1:0]      req_ready;
    logic [N_REQ*IN_W-1:0] req_prob;
    logic [IN_W-1:0]       lut_in;
    logic [OUT_W-1:0]      lut_out;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [OUT_W-1:0]      rsp_data;
    logic [ID_W-1:0]       rsp_id;

    modport slave (
        input  req_valid, req_prob, lut_out, rsp_ready,
        output req_ready, lut_in, rsp_valid, rsp_data, rsp_id
    );

    modport master (
        output req_valid, req_prob, lut_out, rsp_ready,
        input  req_ready, lut_in, rsp_valid, rsp_data, rsp_id
    );
endinterface

// File: rtl/cross_entropy_lut_arbiter.sv
// Round-robin arbiter sharing one cross-entropy gradient table between N_REQ requesters.
// Define CE_ACC_EN to add a saturating 20-bit accumulator of returned gradients.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | no lookup in flight, a request may be accepted
// S_LOOKUP | lut_in holds the granted probability, table output settles
// S_HOLD   | response presented; a handshake may accept the next request
module cross_entropy_lut_arbiter #(
    parameter int N_REQ = 4,
    parameter int IN_W  = 12,
    parameter int OUT_W = 13,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                          clk,
    input  logic                          reset,
`ifdef CE_ACC_EN
    input  logic                          acc_clr,
    output logic signed [19:0]            acc_sum,
`endif
    cross_entropy_lut_arbiter_if.slave    bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOOKUP = 2'd1;
    localparam logic [1:0] S_HOLD   = 2'd2;

    logic [1:0]       r_state;
    logic [ID_W-1:0]  r_last_grant;
    logic [ID_W-1:0]  r_gid;
    logic [IN_W-1:0]  r_lut_in;
    logic             r_rsp_valid;
    logic [OUT_W-1:0] r_rsp_data;
    logic [ID_W-1:0]  r_rsp_id;

    logic             w_found;
    logic [ID_W-1:0]  w_gnt;
    logic             w_hs;
    logic             w_accept;
    logic [N_REQ-1:0] w_ready;

    // Circular search starting one past the last winner.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            int idx;
            idx = (int'(r_last_grant) + k) % N_REQ;
            if (!w_found && bus.req_valid[idx]) begin
                w_found = 1'b1;
                w_gnt   = ID_W'(idx);
            end
        end
    end

    assign w_hs     = r_rsp_valid && bus.rsp_ready;
    assign w_accept = !reset && w_found &&
                      ((r_state == S_IDLE) || ((r_state == S_HOLD) && w_hs));

    always_comb begin
        w_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_ready[i] = w_accept && (w_gnt == ID_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_last_grant <= ID_W'(N_REQ - 1);
            r_gid        <= '0;
            r_lut_in     <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_id     <= '0;
        end else begin
            if (w_accept) begin
                r_lut_in     <= bus.req_prob[int'(w_gnt)*IN_W +: IN_W];
                r_gid        <= w_gnt;
                r_last_grant <= w_gnt;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_accept) r_state <= S_LOOKUP;
                end
                S_LOOKUP: begin
                    r_rsp_data  <= bus.lut_out;
                    r_rsp_id    <= r_gid;
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_HOLD;
                end
                S_HOLD: begin
                    if (w_hs) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= w_accept ? S_LOOKUP : S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.lut_in    = r_lut_in;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_id    = r_rsp_id;

`ifdef CE_ACC_EN
    logic signed [19:0] r_acc;
    logic signed [20:0] w_ext;
    logic signed [20:0] w_sum;
    logic signed [19:0] w_sat;

    assign w_ext = {{(21-OUT_W){r_rsp_data[OUT_W-1]}}, r_rsp_data};
    assign w_sum = {r_acc[19], r_acc} + w_ext;

    always_comb begin
        w_sat = w_sum[19:0];
        if (w_sum > 21'sd524287)       w_sat = 20'sh7FFFF;
        else if (w_sum < -21'sd524288) w_sat = 20'sh80000;
    end

    // A clear that lands on a handshake keeps only that cycle's gradient.
    always_ff @(posedge clk) begin
        if (reset)        r_acc <= '0;
        else if (acc_clr) r_acc <= w_hs ? w_ext[19:0] : 20'sd0;
        else if (w_hs)    r_acc <= w_sat;
    end

    assign acc_sum = r_acc;
`endif
endmodule

// File: tb/tb_cross_entropy_lut_arbiter.sv
// Directed bench for cross_entropy_lut_arbiter with a behavioural -4096/p gradient table.
module tb_cross_entropy_lut_arbiter;
    localparam int N_REQ = 4;
    localparam int IN_W  = 12;
    localparam int OUT_W = 13;
    localparam int ID_W  = 2;

    logic clk;
    logic reset;
    int   n_pass;
    int   n_fail;
    int   n_total;

    cross_entropy_lut_arbiter_if #(.N_REQ(N_REQ), .IN_W(IN_W), .OUT_W(OUT_W), .ID_W(ID_W)) bus();

`ifdef CE_ACC_EN
    logic               acc_clr;
    logic signed [19:0] acc_sum;
`endif

    cross_entropy_lut_arbiter #(.N_REQ(N_REQ), .IN_W(IN_W), .OUT_W(OUT_W), .ID_W(ID_W)) dut (
        .clk     (clk),
        .reset   (reset),
`ifdef CE_ACC_EN
        .acc_clr (acc_clr),
        .acc_sum (acc_sum),
`endif
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    // Gradient table: -4096/p, with p=0 mapped to -4096.
    always_comb begin
        int p;
        p = int'(bus.lut_in);
        if (p == 0) bus.lut_out = OUT_W'(-4096);
        else        bus.lut_out = OUT_W'(-(4096 / p));
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_prob(input int i, input int p);
        bus.req_prob[i*IN_W +: IN_W] = IN_W'(p);
    endtask

    initial begin
        int exp_data [4];
        int fair_data;
        int fair_id;
        int hs;
        int cyc;
        bit seen128;
        clk = 1'b0;
        n_pass = 0;
        n_fail = 0;
        n_total = 0;
        reset = 1'b1;
        bus.req_valid = '0;
        bus.req_prob  = '0;
        bus.rsp_ready = 1'b1;
`ifdef CE_ACC_EN
        acc_clr = 1'b0;
`endif
        tick;
        tick;

        // Reset state, with a request pending that must not be acknowledged.
        bus.req_valid = 4'b0001;
        #1;
        chk("rst_ready", bus.req_ready, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_lut_in", bus.lut_in, 0);
        chk("rst_rsp_data", $signed(bus.rsp_data), 0);
        chk("rst_rsp_id", bus.rsp_id, 0);
        bus.req_valid = '0;
        tick;
        reset = 1'b0;

        // Single request, p=4 -> -1024, latency two cycles.
        set_prob(0, 4);
        bus.req_valid = 4'b0001;
        #1;
        chk("single_ready", bus.req_ready, 1);
        tick;
        bus.req_valid = '0;
        #1;
        chk("single_lookup_valid", bus.rsp_valid, 0);
        chk("single_lut_in", bus.lut_in, 4);
        tick;
        chk("single_valid", bus.rsp_valid, 1);
        chk("single_data", $signed(bus.rsp_data), -1024);
        chk("single_id", bus.rsp_id, 0);
        tick;
        chk("single_done", bus.rsp_valid, 0);

        // Four simultaneous requests after reset: ids 0..3 two cycles apart.
        reset = 1'b1;
        tick;
        reset = 1'b0;
        exp_data = '{-4096, -2048, -512, -1};
        set_prob(0, 1);
        set_prob(1, 2);
        set_prob(2, 8);
        set_prob(3, 4095);
        bus.req_valid = 4'b1111;
        #1;
        chk("all_ready0", bus.req_ready, 1);
        for (int k = 0; k < 4; k++) begin
            tick;
            bus.req_valid[k] = 1'b0;
            #1;
            chk("all_lookup_valid", bus.rsp_valid, 0);
            tick;
            chk("all_valid", bus.rsp_valid, 1);
            chk("all_id", bus.rsp_id, k);
            chk("all_data", $signed(bus.rsp_data), exp_data[k]);
            chk("all_next_ready", bus.req_ready, (k < 3) ? (1 << (k + 1)) : 0);
        end
        tick;
        chk("all_idle", bus.rsp_valid, 0);

        // Backpressure: response held while req1 waits.
        bus.rsp_ready = 1'b0;
        set_prob(0, 16);
        set_prob(1, 1024);
        bus.req_valid = 4'b0001;
        #1;
        chk("bp_ready0", bus.req_ready, 1);
        tick;
        bus.req_valid = 4'b0010;
        tick;
        for (int c = 0; c < 5; c++) begin
            chk("bp_valid", bus.rsp_valid, 1);
            chk("bp_data", $signed(bus.rsp_data), -256);
            chk("bp_id", bus.rsp_id, 0);
            chk("bp_no_ready", bus.req_ready, 0);
            tick;
        end
        bus.rsp_ready = 1'b1;
        #1;
        chk("bp_hs_ready", bus.req_ready, 2);
        tick;
        bus.req_valid = '0;
        tick;
        chk("bp_rsp1_id", bus.rsp_id, 1);
        chk("bp_rsp1_data", $signed(bus.rsp_data), -4);
        tick;

        // Fairness between req0 and req2 held valid.
        reset = 1'b1;
        tick;
        reset = 1'b0;
        set_prob(0, 16);
        set_prob(2, 1024);
        bus.req_valid = 4'b0101;
        #1;
        chk("fair_ready0", bus.req_ready, 1);
        for (int k = 0; k < 4; k++) begin
            fair_id   = (k % 2 == 0) ? 0 : 2;
            fair_data = (k % 2 == 0) ? -256 : -4;
            tick;
            tick;
            chk("fair_valid", bus.rsp_valid, 1);
            chk("fair_id", bus.rsp_id, fair_id);
            chk("fair_data", $signed(bus.rsp_data), fair_data);
            chk("fair_next_ready", bus.req_ready, (k % 2 == 0) ? 4 : 1);
        end
        bus.req_valid = '0;
        tick;
        tick;
        tick;

        // Reset during LOOKUP discards the response and restores req0 priority.
        set_prob(1, 2);
        bus.req_valid = 4'b0010;
        #1;
        chk("rl_ready1", bus.req_ready, 2);
        tick;
        reset = 1'b1;
        set_prob(0, 8);
        bus.req_valid = 4'b0011;
        #1;
        chk("rl_rst_ready", bus.req_ready, 0);
        tick;
        reset = 1'b0;
        #1;
        chk("rl_rsp_valid", bus.rsp_valid, 0);
        chk("rl_grant0", bus.req_ready, 1);
        tick;
        bus.req_valid = 4'b0010;
        tick;
        chk("rl_rsp0_id", bus.rsp_id, 0);
        chk("rl_rsp0_data", $signed(bus.rsp_data), -512);
        chk("rl_grant1", bus.req_ready, 2);
        tick;
        bus.req_valid = '0;
        tick;
        chk("rl_rsp1_id", bus.rsp_id, 1);
        chk("rl_rsp1_data", $signed(bus.rsp_data), -2048);
        tick;
        chk("rl_idle", bus.rsp_valid, 0);

`ifdef CE_ACC_EN
        // Accumulator saturation after 128 responses of -4096, then clear.
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("acc_reset", acc_sum, 0);
        set_prob(0, 1);
        bus.req_valid = 4'b0001;
        hs = 0;
        cyc = 0;
        seen128 = 1'b0;
        while (hs < 129 && cyc < 2000) begin
            if (bus.rsp_valid) hs++;
            tick;
            cyc++;
            if (hs == 128 && !seen128) begin
                seen128 = 1'b1;
                chk("acc_128", acc_sum, -524288);
            end
        end
        chk("acc_hs_budget", hs, 129);
        bus.req_valid = '0;
        tick;
        tick;
        tick;
        chk("acc_sat", acc_sum, -524288);
        acc_clr = 1'b1;
        tick;
        acc_clr = 1'b0;
        chk("acc_clr", acc_sum, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
